store_merge: RTL

STORE_MERGE -- requirements
Module: store_merge

---
 rtl/store_merge_if.sv | 37 +++
 rtl/store_merge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_if.sv
// store_merge_if: store request port plus word-wide memory port of store_merge.
// slave  - the store_merge side (accepts stores, drives memory requests).
// master - the requester/memory side (drives stores, answers memory requests).
interface store_merge_if;
  // store request side
  logic        st_req;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_done;
  logic        st_err;

  // word memory side
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport slave (
    input  st_req, st_op, st_addr, st_data,
    input  mem_rdata, mem_rvalid, mem_ack,
    output st_ready, st_done, st_err,
    output mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );

  modport master (
    output st_req, st_op, st_addr, st_data,
    output mem_rdata, mem_rvalid, mem_ack,
    input  st_ready, st_done, st_err,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_merge.sv
// store_merge: maps byte/half/word stores onto a word-wide memory port.
// Build option STORE_MERGE_BYTE_EN_EN:
//   defined   - byte-enable mode: sub-word stores are written directly with a
//               lane mask and replicated data; READ is never entered.
//   undefined - sb/sh do a read-modify-write of the containing word.
// sw is always a direct full-word write with all byte enables set.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | st_ready high, waiting for st_req
// READ  | mem_rd high, waiting for mem_rvalid (RMW mode only)
// WRITE | mem_wr high, wdata/be held stable, waiting for mem_ack
// DONE  | st_done pulse, always back to IDLE next cycle
module store_merge (
  input  logic         clk,
  input  logic         reset,
  store_merge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SB  = 2'b01;
  localparam logic [1:0] OP_SH  = 2'b10;
  localparam logic [1:0] OP_SW  = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;

  // latched request
  logic [1:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_data;

  // write beat presented to memory
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_err;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_accept_err;
  logic        w_accept_wr;
  logic        w_st_ready;
  logic        w_st_done;
  logic        w_mem_rd;
  logic        w_mem_wr;

  // Byte lanes touched by a store of this size at this word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (op)
      OP_SB:   m = 4'b0001 << a;
      OP_SH:   m = a[1] ? 4'b1100 : 4'b0011;
      OP_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Right-aligned store data copied into every lane it could land in, so
  // any lane mask can pick its bytes straight out of the result.
  function automatic logic [31:0] replicate(input logic [1:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Lanes selected by mask come from the new data, the rest from the old word.
  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        r[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign w_accept     = bus.st_req && (r_state == IDLE);
  assign w_misaligned = ((bus.st_op == OP_SH) && bus.st_addr[0]) ||
                        ((bus.st_op == OP_SW) && (bus.st_addr[1:0] != 2'b00));
  assign w_accept_err = w_accept && (bus.st_op != OP_NOP) && w_misaligned;
  assign w_accept_wr  = w_accept && (bus.st_op != OP_NOP) && !w_misaligned;

  // State register; reset drops straight to IDLE so mem_rd/mem_wr fall at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_st_ready  = 1'b0;
    w_st_done   = 1'b0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_st_ready = 1'b1;
        if (bus.st_req) begin
          if (bus.st_op == OP_NOP) begin
            w_state_nxt = DONE;
          end else if (w_misaligned) begin
            w_state_nxt = IDLE;
          end else if (bus.st_op == OP_SW) begin
            w_state_nxt = WRITE;
          end else begin
`ifdef STORE_MERGE_BYTE_EN_EN
            w_state_nxt = WRITE;
`else
            w_state_nxt = READ;
`endif
          end
        end
      end
      READ: begin
`ifdef STORE_MERGE_BYTE_EN_EN
        w_state_nxt = IDLE;
`else
        w_mem_rd = 1'b1;
        if (bus.mem_rvalid) begin
          w_state_nxt = WRITE;
        end
`endif
      end
      WRITE: begin
        w_mem_wr = 1'b1;
        if (bus.mem_ack) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_st_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, error pulse and write-beat formation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_NOP;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'b0000;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept_err;
      if (w_accept) begin
        r_op   <= bus.st_op;
        r_addr <= bus.st_addr;
        r_data <= bus.st_data;
      end
      // Direct writes (sw, or anything in byte-enable mode) are fully known
      // at acceptance; in RMW mode sb/sh overwrite wdata when the read returns.
      if (w_accept_wr) begin
        r_wdata <= replicate(bus.st_op, bus.st_data);
`ifdef STORE_MERGE_BYTE_EN_EN
        r_be    <= lane_mask(bus.st_op, bus.st_addr[1:0]);
`else
        r_be    <= 4'b1111;
`endif
      end
`ifndef STORE_MERGE_BYTE_EN_EN
      if ((r_state == READ) && bus.mem_rvalid) begin
        r_wdata <= merge(bus.mem_rdata, replicate(r_op, r_data),
                         lane_mask(r_op, r_addr[1:0]));
      end
`endif
    end
  end

`ifdef STORE_MERGE_BYTE_EN_EN
  // Read channel and sub-word offset are not needed without RMW.
  logic w_unused;
  assign w_unused = ^{bus.mem_rdata, bus.mem_rvalid, r_op, r_data, r_addr[1:0]};
`endif

  assign bus.st_ready  = w_st_ready;
  assign bus.st_done   = w_st_done;
  assign bus.st_err    = r_err;
  assign bus.mem_rd    = w_mem_rd;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.mem_addr  = {r_addr[31:2], 2'b00};
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_be    = r_be;

endmodule
